// File: rtl/scatter_obm_pkt_buf.sv
// Store-and-forward packet buffer behind the scatter stage: clean packets are committed
// into a circular beat RAM at eop and replayed in order on a ready/valid stream.
module scatter_obm_pkt_buf #(
    parameter int ADDR_W    = 9,
    parameter int DESC_W    = 4,
    parameter int MAX_BEATS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] m_scatter_obm_data,
    input  logic [4:0]   m_scatter_obm_mod,
    input  logic         m_scatter_obm_valid,
    input  logic         m_scatter_obm_sop,
    input  logic         m_scatter_obm_eop,
    input  logic         m_scatter_obm_err,
    input  logic [2:0]   m_scatter_obm_ophb,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [255:0] o_data,
    output logic         o_sop,
    output logic         o_eop,
    output logic [4:0]   o_mod,
    output logic [2:0]   o_ophb,
    output logic [15:0]  o_len,
    output logic [15:0]  drop_cnt,
    output logic [15:0]  frame_err_cnt
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int DDEPTH = 1 << DESC_W;
    localparam int PW     = ADDR_W + 1;
    localparam int CW     = $clog2(MAX_BEATS + 1);

    typedef enum logic {W_IDLE, W_PKT} wstate_t;
    typedef enum logic {R_IDLE, R_PKT} rstate_t;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [4:0]  mod;
        logic [2:0]  ophb;
        logic [15:0] len;
    } meta_t;

    function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, c} + {15'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // storage
    logic [255:0]    mem        [DEPTH];
    logic [PW-1:0]   desc_start [DDEPTH];
    logic [15:0]     desc_len   [DDEPTH];
    logic [2:0]      desc_ophb  [DDEPTH];

    // write side
    wstate_t         wstate, wstate_nxt;
    logic [PW-1:0]   wr_ptr, commit_ptr, start_ptr, wp_base, wp_after;
    logic [CW-1:0]   beat_cnt, cnt_base, cnt_nxt;
    logic            bad, bad_nxt;
    logic [2:0]      ophb_q, ophb_cur;
    logic [DESC_W:0] dw_ptr, dr_ptr;
    logic            fresh, abort, stray, accept, wfull, over, do_write, eop_now, commit;
    logic            desc_empty, desc_full;
    logic [15:0]     len_cur;
    logic [1:0]      drop_inc, frame_inc;

    // read side
    rstate_t         rstate, rstate_nxt;
    logic [PW-1:0]   rd_ptr, rd_ptr_nxt;
    logic [15:0]     beat_rem, cur_len, head_beats;
    logic [2:0]      cur_ophb;
    logic            cur_first, desc_pop, rd_issue, can_issue;
    logic [255:0]    ram_q;
    logic            inflight;
    meta_t           meta_i, meta_q;
    logic [255:0]    ent_data [2];
    meta_t           ent_meta [2];
    logic            head, widx, pop;
    logic [1:0]      ocnt, occ_after;

    // The open packet always starts at the last commit point, so a rewind can never
    // retreat past committed data.
    assign start_ptr  = commit_ptr;
    assign desc_empty = (dw_ptr == dr_ptr);
    assign desc_full  = ((dw_ptr - dr_ptr) == (DESC_W + 1)'(DDEPTH));

    always_comb begin
        wstate_nxt = wstate;
        fresh      = m_scatter_obm_valid & m_scatter_obm_sop;
        abort      = fresh & (wstate == W_PKT);
        stray      = m_scatter_obm_valid & ~m_scatter_obm_sop & (wstate == W_IDLE);
        accept     = fresh | (m_scatter_obm_valid & (wstate == W_PKT));
        wp_base    = abort ? start_ptr : wr_ptr;
        cnt_base   = fresh ? '0 : beat_cnt;
        ophb_cur   = fresh ? m_scatter_obm_ophb : ophb_q;
        // space is judged against the read pointer after this cycle's read
        wfull      = ((wp_base - rd_ptr_nxt) == PW'(DEPTH));
        over       = (cnt_base >= CW'(MAX_BEATS));
        do_write   = accept & ~wfull & ~over;
        cnt_nxt    = over ? cnt_base : cnt_base + CW'(1);
        bad_nxt    = (~fresh & bad) | m_scatter_obm_err | wfull | over;
        wp_after   = wp_base + {{(PW-1){1'b0}}, do_write};
        eop_now    = accept & m_scatter_obm_eop;
        commit     = eop_now & ~bad_nxt & (~desc_full | desc_pop);
        len_cur    = (16'(cnt_nxt) << 5) - {11'd0, m_scatter_obm_mod};
        drop_inc   = {1'b0, abort} + {1'b0, eop_now & ~commit};
        frame_inc  = {1'b0, abort} + {1'b0, stray};
        if (accept)
            wstate_nxt = m_scatter_obm_eop ? W_IDLE : W_PKT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate        <= W_IDLE;
            wr_ptr        <= '0;
            commit_ptr    <= '0;
            beat_cnt      <= '0;
            bad           <= 1'b0;
            ophb_q        <= '0;
            dw_ptr        <= '0;
            drop_cnt      <= '0;
            frame_err_cnt <= '0;
        end else begin
            wstate        <= wstate_nxt;
            drop_cnt      <= sat_add(drop_cnt, drop_inc);
            frame_err_cnt <= sat_add(frame_err_cnt, frame_inc);
            if (accept) begin
                wr_ptr   <= (eop_now & ~commit) ? start_ptr : wp_after;
                beat_cnt <= cnt_nxt;
                bad      <= bad_nxt;
            end
            if (fresh)
                ophb_q <= m_scatter_obm_ophb;
            if (commit) begin
                commit_ptr <= wp_after;
                dw_ptr     <= dw_ptr + 1'b1;
            end
        end
    end

    // RAM and descriptor array; read-first, so a slot freed by this cycle's read may be rewritten
    always_ff @(posedge clk) begin
        if (do_write)
            mem[wp_base[ADDR_W-1:0]] <= m_scatter_obm_data;
        if (rd_issue)
            ram_q <= mem[rd_ptr[ADDR_W-1:0]];
        if (commit) begin
            desc_start[dw_ptr[DESC_W-1:0]] <= start_ptr;
            desc_len[dw_ptr[DESC_W-1:0]]   <= len_cur;
            desc_ophb[dw_ptr[DESC_W-1:0]]  <= ophb_cur;
        end
    end

    // Read issue: a read is launched only if the 2-entry output queue has room once the
    // beat already in flight lands, so stalls never lose RAM data.
    assign pop        = o_valid & o_ready;
    assign occ_after  = ocnt + {1'b0, inflight} - {1'b0, pop};
    assign can_issue  = (occ_after < 2'd2);
    assign head_beats = (desc_len[dr_ptr[DESC_W-1:0]] + 16'd31) >> 5;

    always_comb begin
        rstate_nxt = rstate;
        desc_pop   = 1'b0;
        rd_issue   = 1'b0;
        case (rstate)
            R_IDLE: if (!desc_empty) begin
                desc_pop   = 1'b1;
                rstate_nxt = R_PKT;
            end
            R_PKT: if (can_issue) begin
                rd_issue = 1'b1;
                if (beat_rem == 16'd1) begin
                    if (!desc_empty) desc_pop = 1'b1;
                    else             rstate_nxt = R_IDLE;
                end
            end
            default: rstate_nxt = R_IDLE;
        endcase
        rd_ptr_nxt  = desc_pop ? desc_start[dr_ptr[DESC_W-1:0]]
                               : rd_ptr + {{(PW-1){1'b0}}, rd_issue};
        meta_i.sop  = cur_first;
        meta_i.eop  = (beat_rem == 16'd1);
        meta_i.mod  = meta_i.eop ? 5'd0 - cur_len[4:0] : 5'd0;
        meta_i.ophb = cur_ophb;
        meta_i.len  = cur_len;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate    <= R_IDLE;
            rd_ptr    <= '0;
            dr_ptr    <= '0;
            beat_rem  <= '0;
            cur_len   <= '0;
            cur_ophb  <= '0;
            cur_first <= 1'b0;
            inflight  <= 1'b0;
            meta_q    <= '0;
        end else begin
            rstate   <= rstate_nxt;
            inflight <= rd_issue;
            if (rd_issue)
                meta_q <= meta_i;
            if (desc_pop) begin
                rd_ptr    <= desc_start[dr_ptr[DESC_W-1:0]];
                beat_rem  <= head_beats;
                cur_len   <= desc_len[dr_ptr[DESC_W-1:0]];
                cur_ophb  <= desc_ophb[dr_ptr[DESC_W-1:0]];
                cur_first <= 1'b1;
                dr_ptr    <= dr_ptr + 1'b1;
            end else if (rd_issue) begin
                rd_ptr    <= rd_ptr + 1'b1;
                beat_rem  <= beat_rem - 16'd1;
                cur_first <= 1'b0;
            end
        end
    end

    // Output queue: per-beat metadata travels with the data so o_len/o_ophb stay tied
    // to their packet even when the next descriptor has already been popped.
    assign widx = head ^ (ocnt == 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head        <= 1'b0;
            ocnt        <= '0;
            ent_data[0] <= '0;
            ent_data[1] <= '0;
            ent_meta[0] <= '0;
            ent_meta[1] <= '0;
        end else begin
            if (inflight) begin
                ent_data[widx] <= ram_q;
                ent_meta[widx] <= meta_q;
            end
            if (pop)
                head <= ~head;
            ocnt <= ocnt + {1'b0, inflight} - {1'b0, pop};
        end
    end

    assign o_valid = (ocnt != 2'd0);
    assign o_data  = ent_data[head];
    assign o_sop   = o_valid & ent_meta[head].sop;
    assign o_eop   = o_valid & ent_meta[head].eop;
    assign o_mod   = o_valid ? ent_meta[head].mod : 5'd0;
    assign o_ophb  = ent_meta[head].ophb;
    assign o_len   = ent_meta[head].len;

endmodule

// File: tb/tb_scatter_obm_pkt_buf.sv
// Scoreboard bench for scatter_obm_pkt_buf: a default-size instance and a 16-beat RAM instance.
module tb_scatter_obm_pkt_buf;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] din   [2];
    logic [4:0]   dmod  [2];
    logic         dv    [2];
    logic         dsop  [2];
    logic         deop  [2];
    logic         derr  [2];
    logic [2:0]   dophb [2];
    logic         rdy   [2];
    logic         ov    [2];
    logic [255:0] odata [2];
    logic         osop  [2];
    logic         oeop  [2];
    logic [4:0]   omod  [2];
    logic [2:0]   oophb [2];
    logic [15:0]  olen  [2];
    logic [15:0]  dropc [2];
    logic [15:0]  ferrc [2];

    int n_chk = 0;
    int n_err = 0;
    int exp_drop0 = 0, exp_ferr0 = 0, exp_drop1 = 0;
    logic [281:0] q0[$];
    logic [281:0] q1[$];

    always #5 clk = ~clk;

    scatter_obm_pkt_buf dut0 (
        .clk(clk), .rst_n(rst_n),
        .m_scatter_obm_data(din[0]), .m_scatter_obm_mod(dmod[0]), .m_scatter_obm_valid(dv[0]),
        .m_scatter_obm_sop(dsop[0]), .m_scatter_obm_eop(deop[0]), .m_scatter_obm_err(derr[0]),
        .m_scatter_obm_ophb(dophb[0]),
        .o_valid(ov[0]), .o_ready(rdy[0]), .o_data(odata[0]), .o_sop(osop[0]), .o_eop(oeop[0]),
        .o_mod(omod[0]), .o_ophb(oophb[0]), .o_len(olen[0]),
        .drop_cnt(dropc[0]), .frame_err_cnt(ferrc[0])
    );

    scatter_obm_pkt_buf #(.ADDR_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .m_scatter_obm_data(din[1]), .m_scatter_obm_mod(dmod[1]), .m_scatter_obm_valid(dv[1]),
        .m_scatter_obm_sop(dsop[1]), .m_scatter_obm_eop(deop[1]), .m_scatter_obm_err(derr[1]),
        .m_scatter_obm_ophb(dophb[1]),
        .o_valid(ov[1]), .o_ready(rdy[1]), .o_data(odata[1]), .o_sop(osop[1]), .o_eop(oeop[1]),
        .o_mod(omod[1]), .o_ophb(oophb[1]), .o_len(olen[1]),
        .drop_cnt(dropc[1]), .frame_err_cnt(ferrc[1])
    );

    task automatic chk(input string tag, input logic [281:0] act, input logic [281:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [281:0] obeat(input int s);
        return {odata[s], osop[s], oeop[s], omod[s], oophb[s], olen[s]};
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // scoreboard: compare the head beat every cycle it is offered, retire it on handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (ov[0]) begin
                if (q0.size() == 0) chk("unexpected0", 282'(1), 282'(0));
                else begin
                    chk("beat0", obeat(0), q0[0]);
                    if (rdy[0]) void'(q0.pop_front());
                end
            end
            if (ov[1]) begin
                if (q1.size() == 0) chk("unexpected1", 282'(1), 282'(0));
                else begin
                    chk("beat1", obeat(1), q1[0]);
                    if (rdy[1]) void'(q1.pop_front());
                end
            end
        end
    end

    task automatic drive_beat(input int s, input logic v, input logic sop, input logic eop,
                              input logic [4:0] mod, input logic err, input logic [2:0] ophb,
                              input logic [255:0] d);
        @(posedge clk); #1;
        dv[s] = v; dsop[s] = sop; deop[s] = eop; dmod[s] = mod;
        derr[s] = err; dophb[s] = ophb; din[s] = d;
    endtask

    task automatic idle(input int s, input int n);
        for (int i = 0; i < n; i++) drive_beat(s, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, '0);
    endtask

    task automatic send_pkt(input int s, input int n, input logic [4:0] mod, input logic [2:0] ophb,
                            input int err_beat, input bit keep);
        logic [255:0] d;
        logic [15:0]  len;
        logic         l;
        len = 16'(n * 32) - {11'd0, mod};
        for (int b = 0; b < n; b++) begin
            d = rnd256();
            l = (b == n - 1);
            if (keep) begin
                if (s == 0) q0.push_back({d, b == 0, l, l ? mod : 5'd0, ophb, len});
                else        q1.push_back({d, b == 0, l, l ? mod : 5'd0, ophb, len});
            end
            drive_beat(s, 1'b1, b == 0, l, mod, b == err_beat, ophb, d);
        end
    endtask

    task automatic drain(input int s, input string tag);
        int left;
        for (int i = 0; i < 300; i++) begin
            left = (s == 0) ? q0.size() : q1.size();
            if (left == 0) break;
            @(posedge clk);
        end
        left = (s == 0) ? q0.size() : q1.size();
        chk(tag, 282'(left), 282'(0));
        @(posedge clk); #1;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_drop0"}, 282'(dropc[0]), 282'(exp_drop0));
        chk({tag, "_ferr0"}, 282'(ferrc[0]), 282'(exp_ferr0));
        chk({tag, "_drop1"}, 282'(dropc[1]), 282'(exp_drop1));
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            dv[s] = 0; dsop[s] = 0; deop[s] = 0; derr[s] = 0; dmod[s] = 0; dophb[s] = 0;
            din[s] = '0; rdy[s] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_beat", obeat(0), '0);
        chk("rst_valid", 282'(ov[0]), 282'(0));
        chk_cnt("rst");
        rst_n = 1'b1;

        // single-beat packet and first-beat latency
        send_pkt(0, 1, 5'd30, 3'd5, -1, 1);
        idle(0, 1);
        seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            if (ov[0]) seen = 1;
        end
        chk("latency", 282'(seen), 282'(1));
        drain(0, "drain_1beat");
        chk_cnt("one");

        // errored packet dropped, clean follower delivered with len 64
        send_pkt(0, 4, 5'd7, 3'd2, 1, 0);
        send_pkt(0, 2, 5'd0, 3'd3, -1, 1);
        idle(0, 1);
        exp_drop0++;
        drain(0, "drain_err");
        chk_cnt("err");

        // back-to-back packets with a 10-cycle stall in the middle of delivery
        fork
            begin
                send_pkt(0, 6, 5'd4, 3'd1, -1, 1);
                send_pkt(0, 3, 5'd31, 3'd6, -1, 1);
                send_pkt(0, 5, 5'd16, 3'd7, -1, 1);
                idle(0, 1);
            end
            begin
                repeat (11) @(posedge clk);
                #1 rdy[0] = 1'b0;
                repeat (10) @(posedge clk);
                #1 rdy[0] = 1'b1;
            end
        join
        drain(0, "drain_stall");

        // oversize drop, then the largest legal packet
        send_pkt(0, 65, 5'd0, 3'd4, -1, 0);
        exp_drop0++;
        send_pkt(0, 64, 5'd1, 3'd2, -1, 1);
        idle(0, 1);
        drain(0, "drain_max");
        chk_cnt("size");

        // stray beat, then a sop arriving inside an open packet
        drive_beat(0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 3'd1, rnd256());
        idle(0, 2);
        exp_ferr0++;
        chk_cnt("stray");
        drive_beat(0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 3'd3, rnd256());
        drive_beat(0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 3'd3, rnd256());
        send_pkt(0, 3, 5'd9, 3'd5, -1, 1);
        idle(0, 1);
        exp_ferr0++;
        exp_drop0++;
        drain(0, "drain_abort");
        chk_cnt("abort");

        // 16-beat RAM: overflowing packet dropped while stalled, then a fitting one delivered
        rdy[1] = 1'b0;
        send_pkt(1, 20, 5'd0, 3'd1, -1, 0);
        idle(1, 2);
        exp_drop1++;
        chk_cnt("ovf");
        rdy[1] = 1'b1;
        send_pkt(1, 4, 5'd0, 3'd6, -1, 1);
        idle(1, 1);
        drain(1, "drain_small");
        chk_cnt("small");

        // reset with buffered packets and one half-written
        rdy[0] = 1'b0;
        send_pkt(0, 3, 5'd2, 3'd1, -1, 1);
        send_pkt(0, 2, 5'd5, 3'd2, -1, 1);
        drive_beat(0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 3'd3, rnd256());
        drive_beat(0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 3'd3, rnd256());
        @(posedge clk); #1;
        rst_n = 1'b0;
        dv[0] = 1'b0;
        #1;
        chk("rstmid_valid", 282'(ov[0]), 282'(0));
        chk("rstmid_beat", obeat(0), '0);
        q0.delete();
        q1.delete();
        exp_drop0 = 0; exp_ferr0 = 0; exp_drop1 = 0;
        chk_cnt("rstmid");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rdy[0] = 1'b1;
        send_pkt(0, 3, 5'd12, 3'd4, -1, 1);
        idle(0, 1);
        drain(0, "drain_post_rst");
        chk_cnt("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
